// File: rtl/eca_stripe_ctrl_if.sv
// Job, BM SRAM, buffer and engine handshake bundle for eca_stripe_ctrl.
// Defining ECA_PERF_CNT_EN adds the perf_cycles/perf_stalls outputs.
interface eca_stripe_ctrl_if #(
    parameter int unsigned K_MAX    = 4,
    parameter int unsigned M_MAX    = 128,
    parameter int unsigned STRIPE_W = 16
);
    localparam int unsigned ADDR_W = $clog2(M_MAX);
    localparam int unsigned K_W    = $clog2(K_MAX) + 1;

    // Register / user side
    logic                cfg_wr;
    logic [K_W-1:0]      cfg_k;
    logic [ADDR_W:0]     cfg_m;
    logic [STRIPE_W-1:0] cfg_stripes;
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                cfg_err;

    // BM SRAM side
    logic                bm_rd_req;
    logic [ADDR_W-1:0]   bm_rd_addr;
    logic                bm_rd_val;

    // Engine and buffer side
    logic                eng_bm_load;
    logic                inbuf_empty;
    logic                inbuf_rd_req;
    logic                outbuf_full;
    logic                eng_calc_en;
    logic                eng_wr_ack;
    logic                eng_empty;

    // Progress
    logic [STRIPE_W-1:0] stripe_idx;
    logic [ADDR_W-1:0]   group_idx;

`ifdef ECA_PERF_CNT_EN
    logic [31:0]         perf_cycles;
    logic [31:0]         perf_stalls;
`endif

    modport master (
        input  cfg_wr, cfg_k, cfg_m, cfg_stripes, start, abort,
        input  bm_rd_val, inbuf_empty, outbuf_full, eng_wr_ack, eng_empty,
`ifdef ECA_PERF_CNT_EN
        output perf_cycles, perf_stalls,
`endif
        output busy, done, cfg_err, bm_rd_req, bm_rd_addr, eng_bm_load,
        output inbuf_rd_req, eng_calc_en, stripe_idx, group_idx
    );

    modport slave (
        output cfg_wr, cfg_k, cfg_m, cfg_stripes, start, abort,
        output bm_rd_val, inbuf_empty, outbuf_full, eng_wr_ack, eng_empty,
`ifdef ECA_PERF_CNT_EN
        input  perf_cycles, perf_stalls,
`endif
        input  busy, done, cfg_err, bm_rd_req, bm_rd_addr, eng_bm_load,
        input  inbuf_rd_req, eng_calc_en, stripe_idx, group_idx
    );
endinterface

// File: rtl/eca_stripe_ctrl.sv
// Job-level stripe x parity-row-group sequencer for the erasure-coding engine.
// Optional ECA_PERF_CNT_EN adds saturating busy-cycle and DATA-stall counters.
module eca_stripe_ctrl #(
    parameter int unsigned K_MAX            = 4,
    parameter int unsigned K_MIN            = 2,
    parameter int unsigned M_MAX            = 128,
    parameter int unsigned BM_MULT_UNIT_NUM = 4,
    parameter int unsigned STRIPE_W         = 16
) (
    input  logic              clk,
    input  logic              rstn,
    eca_stripe_ctrl_if.master bus
);
    localparam int unsigned G       = BM_MULT_UNIT_NUM / K_MIN;
    localparam int unsigned ADDR_W  = $clog2(M_MAX);
    localparam int unsigned OUTST_W = 4;
    localparam int unsigned K_W     = $clog2(K_MAX) + 1;

    localparam logic [OUTST_W-1:0] OutstMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StBmRd,
        StBmWait,
        StData,
        StNext,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [K_W-1:0]      k_q, k_d;
    logic [ADDR_W:0]     m_q, m_d;
    logic [STRIPE_W-1:0] stripes_q, stripes_d;
    logic [ADDR_W:0]     ng_q, ng_d;
    logic [STRIPE_W-1:0] stripe_q, stripe_d;
    logic [ADDR_W-1:0]   group_q, group_d;
    logic [OUTST_W-1:0]  outst_q, outst_d;
    logic                cfg_err_q, cfg_err_d;

    logic                cfg_ok;
    logic                start_ok;
    logic                gate_ok;
    logic                calc_fire;
    logic                drain_done;
    logic                ack_take;
    logic                busy_w;
    logic [ADDR_W:0]     ng_calc;
    logic [ADDR_W:0]     group_inc;
    logic [STRIPE_W:0]   stripe_inc;
    logic                last_group;

    assign cfg_ok = (k_q >= K_W'(K_MIN)) && (k_q <= K_W'(K_MAX)) &&
                    (m_q != '0) && (m_q <= (ADDR_W+1)'(M_MAX)) &&
                    (stripes_q != '0);

    assign start_ok = (state_q == StIdle) && bus.start && cfg_ok && !bus.abort;

    assign ng_calc    = (m_q + (ADDR_W+1)'(G - 1)) / (ADDR_W+1)'(G);
    assign group_inc  = {1'b0, group_q} + (ADDR_W+1)'(1);
    assign stripe_inc = {1'b0, stripe_q} + (STRIPE_W+1)'(1);
    assign last_group = !(group_inc < ng_q);

    // Stripe data is only popped on group 0; later groups reuse the engine's held copy.
    assign gate_ok = !bus.outbuf_full && (outst_q != OutstMax) &&
                     ((group_q != '0) || !bus.inbuf_empty);

    assign calc_fire  = (state_q == StData) && gate_ok && !bus.abort;
    assign drain_done = (state_q == StDrain) && (outst_q == '0) && bus.eng_empty && !bus.abort;
    assign ack_take   = bus.eng_wr_ack && (outst_q != '0);
    assign busy_w     = (state_q != StIdle) && !drain_done;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && cfg_ok) state_d = StBmRd;
                end
                StBmRd: begin
                    state_d = StBmWait;
                end
                StBmWait: begin
                    if (bus.bm_rd_val) state_d = StData;
                end
                StData: begin
                    if (calc_fire) state_d = StNext;
                end
                StNext: begin
                    if (last_group && (stripe_inc == {1'b0, stripes_q})) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StBmRd;
                    end
                end
                StDrain: begin
                    if (drain_done) state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.busy         = busy_w;
        bus.done         = drain_done;
        bus.cfg_err      = cfg_err_q;
        bus.bm_rd_req    = (state_q == StBmRd) && !bus.abort;
        bus.bm_rd_addr   = group_q;
        bus.eng_bm_load  = (state_q == StBmWait) && bus.bm_rd_val && !bus.abort;
        bus.eng_calc_en  = calc_fire;
        bus.inbuf_rd_req = calc_fire && (group_q == '0);
        bus.stripe_idx   = stripe_q;
        bus.group_idx    = group_q;
    end

    // Config, loop indices and outstanding-result tracking
    always_comb begin
        k_d       = k_q;
        m_d       = m_q;
        stripes_d = stripes_q;
        ng_d      = ng_q;
        stripe_d  = stripe_q;
        group_d   = group_q;
        outst_d   = outst_q;
        cfg_err_d = 1'b0;

        if (bus.abort) begin
            stripe_d = '0;
            group_d  = '0;
            outst_d  = '0;
        end else begin
            unique case ({calc_fire, ack_take})
                2'b10:   outst_d = outst_q + OUTST_W'(1);
                2'b01:   outst_d = outst_q - OUTST_W'(1);
                default: outst_d = outst_q;
            endcase

            if (bus.cfg_wr) begin
                if (state_q == StIdle) begin
                    k_d       = bus.cfg_k;
                    m_d       = bus.cfg_m;
                    stripes_d = bus.cfg_stripes;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end

            if ((state_q == StIdle) && bus.start) begin
                if (cfg_ok) begin
                    ng_d     = ng_calc;
                    stripe_d = '0;
                    group_d  = '0;
                    outst_d  = '0;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end

            if (state_q == StNext) begin
                if (!last_group) begin
                    group_d = group_inc[ADDR_W-1:0];
                end else begin
                    group_d  = '0;
                    stripe_d = stripe_inc[STRIPE_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q       <= K_W'(K_MIN);
            m_q       <= (ADDR_W+1)'(1);
            stripes_q <= STRIPE_W'(1);
            ng_q      <= '0;
            stripe_q  <= '0;
            group_q   <= '0;
            outst_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            k_q       <= k_d;
            m_q       <= m_d;
            stripes_q <= stripes_d;
            ng_q      <= ng_d;
            stripe_q  <= stripe_d;
            group_q   <= group_d;
            outst_q   <= outst_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef ECA_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        stall_w;

    assign stall_w = (state_q == StData) && !gate_ok && !bus.abort;

    // Counters freeze once busy drops, so values survive done/abort until the next start.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (start_ok) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy_w && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
            if (stall_w && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif
endmodule

// File: doc/eca_stripe_ctrl.md
Name: eca_stripe_ctrl

Overview:
- Job-level sequencer for the next-generation erasure-coding accelerator. Replaces the fixed MReg/eca_en control path with runtime K, M and stripe count, plus a start/done/abort job interface.
- Iterates stripes × parity-row groups:
  - fetches the bitmatrix row group from the BM SRAM,
  - pops stripe data from the input buffer once per stripe,
  - fires engine calculations under output-buffer back-pressure,
  - tracks outstanding results until the engine drains.
- Sits between the register/user interface and the engine, inbuf, outbuf and BM SRAM.

Parameters:
- K_MAX, 4, maximum data blocks per stripe.
- K_MIN, 2, minimum data blocks per stripe.
- M_MAX, 128, maximum parity rows; BM SRAM depth.
- BM_MULT_UNIT_NUM, 4, number of engine multiply units.
- STRIPE_W, 16, width of the stripe-count register.
- G (local), BM_MULT_UNIT_NUM/K_MIN, parity rows per group.
- ADDR_W (local), $clog2(M_MAX).
- OUTST_W (local), 4; outstanding-result counter width (max 15).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_wr  in  1  config write strobe
- cfg_k  in  $clog2(K_MAX)+1  K value
- cfg_m  in  ADDR_W+1  M value
- cfg_stripes  in  STRIPE_W  stripes per job
- start  in  1  job start pulse
- abort  in  1  job abort pulse
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- cfg_err  out  1  one-cycle error pulse
- bm_rd_req  out  1  BM SRAM read request
- bm_rd_addr  out  ADDR_W  BM row-group address
- bm_rd_val  in  1  BM read data valid
- eng_bm_load  out  1  engine latches BM data
- inbuf_empty  in  1  input FIFO empty
- inbuf_rd_req  out  1  input FIFO pop
- outbuf_full  in  1  output FIFO full
- eng_calc_en  out  1  one-cycle calculate pulse
- eng_wr_ack  in  1  engine result written to outbuf
- eng_empty  in  1  engine pipeline empty
- stripe_idx  out  STRIPE_W  current stripe
- group_idx  out  ADDR_W  current group

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Config registers: K=K_MIN, M=1, stripes=1.
- Config:
  - cfg_wr is accepted only in IDLE.
  - cfg_wr while busy: config is unchanged and cfg_err pulses in the next cycle.
- Start validation:
  - start in IDLE with K_MIN≤K≤K_MAX, 1≤M≤M_MAX and stripes≥1: go to BM_RD next cycle; busy=1 from that cycle.
  - Otherwise: cfg_err pulses and the block stays in IDLE.
  - start while busy is ignored.
- Group count: NG = ceil(M/G), computed at start; stripe_idx and group_idx are cleared.
- BM_RD:
  - bm_rd_req=1 for exactly one cycle, bm_rd_addr=group_idx.
  - Then go to BM_WAIT.
- BM_WAIT:
  - On bm_rd_val: eng_bm_load pulses in the same cycle, go to DATA.
- DATA (group_idx==0):
  - Waits for !inbuf_empty && !outbuf_full && outstanding<15.
  - Then asserts inbuf_rd_req and eng_calc_en together for one cycle.
- DATA (group_idx>0):
  - Only eng_calc_en is pulsed; the engine reuses its held stripe data.
  - Same outbuf_full and outstanding gating applies.
- After the calc pulse, go to NEXT:
  - group_idx+1<NG: group_idx++, go to BM_RD.
  - Else group_idx=0 and stripe_idx++. If the new stripe_idx==stripes, go to DRAIN; else go to BM_RD.
- Outstanding counter:
  - +1 per eng_calc_en, −1 per eng_wr_ack.
  - Simultaneous +1/−1 leaves it unchanged.
  - It never underflows: eng_wr_ack at 0 is ignored.
- DRAIN:
  - When outstanding==0 and eng_empty: done pulses one cycle, busy falls in the same cycle, go to IDLE.
- Abort (any state): next cycle state=IDLE.
  - All request outputs are low, counters and outstanding are cleared, busy=0.
  - No done pulse.
- Abort has priority over start, cfg_wr and all state transitions in the same cycle.
- Asynchronous reset mid-job behaves the same as abort, applied immediately.
- Latency: start to first bm_rd_req is 1 cycle; bm_rd_val to eng_calc_en is at least 1 cycle.

Optional Feature:
- Macro: ECA_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_cycles (32 bits): counts cycles with busy=1.
  - perf_stalls (32 bits): counts cycles in DATA where gating blocked the calc pulse.
- Both counters clear at start, saturate at all-ones, and hold after done or abort.
- When undefined, neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- Defaults (G=2). cfg K=2, M=3, stripes=2; start; inbuf non-empty; ack each calc 2 cycles later.
  - Required: bm_rd_addr sequence 0,1,0,1; 4 eng_calc_en pulses; 2 inbuf_rd_req pulses (groups 0 only).
  - Required: exactly one done pulse after the final ack.
- Validation errors:
  - cfg K=5 then start → cfg_err pulse, busy stays 0.
  - cfg M=0 then start → cfg_err pulse, busy stays 0.
  - cfg_wr during a job → cfg_err pulse, config unchanged.
- Back-pressure: outbuf_full=1 for 10 cycles while in DATA.
  - Required: no eng_calc_en during those cycles; calc fires the cycle after outbuf_full falls.
  - Required: perf_stalls=10 when ECA_PERF_CNT_EN is defined.
- Inbuf empty: hold inbuf_empty=1 on group 0.
  - Required: no inbuf_rd_req and no eng_calc_en until it clears; group 1 proceeds despite inbuf_empty=1.
- Abort: abort on the cycle after the 3rd calc of a 4-calc job.
  - Required: next cycle busy=0, no done pulse, outstanding=0.
  - A new start then runs a full job correctly.
- Drain and counter edge cases: withhold eng_wr_ack until after the last calc.
  - Required: stays in DRAIN with busy=1; done is emitted only when the ack count reaches 0 and eng_empty=1.
  - Simultaneous calc and ack leaves the count unchanged.
